// File: rtl/i2c_readframe.sv
`timescale 1ns/1ps
// I2C master-receiver byte frame: optional START, eight bits clocked in from the
// slave, master ACK/NACK, optional STOP. Every bus phase lasts DELAY cycles.
module i2c_readframe #(
    parameter int DELAY  = 10,
    parameter int SAMPLE = DELAY / 2
) (
    input  logic       clk_1MHz,
    input  logic       rst_n,
    input  logic       en_read,
    input  logic       start_frame,
    input  logic       stop_frame,
    input  logic       ack_last,
    inout  wire        sda,
    output logic       scl,
    output logic       sda_en,
    output logic [7:0] data,
    output logic       done,
    output logic       busy
);

    localparam int PW = $clog2(DELAY);
    localparam logic [PW-1:0] LAST_PHASE   = PW'(DELAY - 1);
    localparam logic [PW-1:0] SAMPLE_PHASE = PW'(SAMPLE);

    localparam logic [3:0] WAIT_EN     = 4'd0;
    localparam logic [3:0] PRE_START   = 4'd1;
    localparam logic [3:0] START       = 4'd2;
    localparam logic [3:0] AFTER_START = 4'd3;
    localparam logic [3:0] READ_LOW    = 4'd4;
    localparam logic [3:0] READ_HIGH   = 4'd5;
    localparam logic [3:0] ACK_LOW     = 4'd6;
    localparam logic [3:0] ACK_HIGH    = 4'd7;
    localparam logic [3:0] ACK_HOLD    = 4'd8;
    localparam logic [3:0] PRE_STOP    = 4'd9;
    localparam logic [3:0] STOP_HIGH   = 4'd10;
    localparam logic [3:0] STOP        = 4'd11;
    localparam logic [3:0] DONE        = 4'd12;

    logic [3:0]    state_r;
    logic [3:0]    state_nxt_s;
    logic [PW-1:0] phase_r;
    logic [PW-1:0] phase_nxt_s;
    logic [3:0]    bit_cnt_r;
    logic [3:0]    bit_cnt_nxt_s;
    logic [7:0]    shift_r;
    logic [7:0]    shift_nxt_s;
    logic [7:0]    data_r;
    logic          done_r;
    logic          busy_r;
    logic          scl_r;
    logic          sda_en_r;
    logic          sda_out_r;
    logic          scl_nxt_s;
    logic          sda_en_nxt_s;
    logic          sda_out_nxt_s;
    logic          start_r;
    logic          stop_r;
    logic          ack_r;
    logic          timed_s;
    logic          phase_end_s;
    logic          sample_s;
    logic          accept_s;

    assign sda    = sda_en_r ? sda_out_r : 1'bz;
    assign scl    = scl_r;
    assign sda_en = sda_en_r;
    assign data   = data_r;
    assign done   = done_r;
    assign busy   = busy_r;

    // Phase timing, sample strobe and the bit/shift next values.
    always_comb begin
        timed_s     = (state_r != WAIT_EN) && (state_r != DONE);
        phase_end_s = timed_s && (phase_r == LAST_PHASE);
        sample_s    = (state_r == READ_HIGH) && (phase_r == SAMPLE_PHASE);
        accept_s    = (state_r == WAIT_EN) && en_read;
        if (timed_s && !phase_end_s) begin
            phase_nxt_s = phase_r + {{(PW-1){1'b0}}, 1'b1};
        end else begin
            phase_nxt_s = {PW{1'b0}};
        end
        if (sample_s) begin
            bit_cnt_nxt_s = bit_cnt_r + 4'd1;
            shift_nxt_s   = {shift_r[6:0], sda};
        end else if ((state_r == ACK_HOLD) && phase_end_s) begin
            bit_cnt_nxt_s = 4'd0;
            shift_nxt_s   = shift_r;
        end else begin
            bit_cnt_nxt_s = bit_cnt_r;
            shift_nxt_s   = shift_r;
        end
    end

    // Next-state decode; the bit count compared is the post-sample value so
    // SAMPLE may legally coincide with the last cycle of ReadHigh.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            WAIT_EN: begin
                if (en_read) begin
                    state_nxt_s = start_frame ? PRE_START : READ_LOW;
                end else begin
                    state_nxt_s = WAIT_EN;
                end
            end
            PRE_START:   if (phase_end_s) state_nxt_s = START;       else state_nxt_s = state_r;
            START:       if (phase_end_s) state_nxt_s = AFTER_START; else state_nxt_s = state_r;
            AFTER_START: if (phase_end_s) state_nxt_s = READ_LOW;    else state_nxt_s = state_r;
            READ_LOW:    if (phase_end_s) state_nxt_s = READ_HIGH;   else state_nxt_s = state_r;
            READ_HIGH: begin
                if (phase_end_s) begin
                    state_nxt_s = (bit_cnt_nxt_s == 4'd8) ? ACK_LOW : READ_LOW;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            ACK_LOW:     if (phase_end_s) state_nxt_s = ACK_HIGH;    else state_nxt_s = state_r;
            ACK_HIGH:    if (phase_end_s) state_nxt_s = ACK_HOLD;    else state_nxt_s = state_r;
            ACK_HOLD: begin
                if (phase_end_s) begin
                    state_nxt_s = stop_r ? PRE_STOP : DONE;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            PRE_STOP:    if (phase_end_s) state_nxt_s = STOP_HIGH;   else state_nxt_s = state_r;
            STOP_HIGH:   if (phase_end_s) state_nxt_s = STOP;        else state_nxt_s = state_r;
            STOP:        if (phase_end_s) state_nxt_s = DONE;        else state_nxt_s = state_r;
            DONE:        state_nxt_s = WAIT_EN;
            default:     state_nxt_s = WAIT_EN;
        endcase
    end

    // Bus line values for the state being entered; WaitEn and Done hold the lines.
    always_comb begin
        scl_nxt_s     = scl_r;
        sda_en_nxt_s  = sda_en_r;
        sda_out_nxt_s = sda_out_r;
        case (state_nxt_s)
            PRE_START:   begin scl_nxt_s = 1'b1; sda_en_nxt_s = 1'b1; sda_out_nxt_s = 1'b1;  end
            START:       begin scl_nxt_s = 1'b1; sda_en_nxt_s = 1'b1; sda_out_nxt_s = 1'b0;  end
            AFTER_START: begin scl_nxt_s = 1'b0; sda_en_nxt_s = 1'b1; sda_out_nxt_s = 1'b0;  end
            READ_LOW:    begin scl_nxt_s = 1'b0; sda_en_nxt_s = 1'b0; sda_out_nxt_s = sda_out_r; end
            READ_HIGH:   begin scl_nxt_s = 1'b1; sda_en_nxt_s = 1'b0; sda_out_nxt_s = sda_out_r; end
            ACK_LOW:     begin scl_nxt_s = 1'b0; sda_en_nxt_s = 1'b1; sda_out_nxt_s = ack_r; end
            ACK_HIGH:    begin scl_nxt_s = 1'b1; sda_en_nxt_s = 1'b1; sda_out_nxt_s = ack_r; end
            ACK_HOLD:    begin scl_nxt_s = 1'b0; sda_en_nxt_s = 1'b1; sda_out_nxt_s = ack_r; end
            PRE_STOP:    begin scl_nxt_s = 1'b0; sda_en_nxt_s = 1'b1; sda_out_nxt_s = 1'b0;  end
            STOP_HIGH:   begin scl_nxt_s = 1'b1; sda_en_nxt_s = 1'b1; sda_out_nxt_s = 1'b0;  end
            STOP:        begin scl_nxt_s = 1'b1; sda_en_nxt_s = 1'b1; sda_out_nxt_s = 1'b1;  end
            default:     begin scl_nxt_s = scl_r; sda_en_nxt_s = sda_en_r; sda_out_nxt_s = sda_out_r; end
        endcase
    end

    // State, counters, received byte, bus lines and status registers.
    always_ff @(posedge clk_1MHz or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= WAIT_EN;
            phase_r   <= {PW{1'b0}};
            bit_cnt_r <= 4'd0;
            shift_r   <= 8'h00;
            data_r    <= 8'h00;
            done_r    <= 1'b0;
            busy_r    <= 1'b0;
            scl_r     <= 1'b1;
            sda_en_r  <= 1'b1;
            sda_out_r <= 1'b1;
            start_r   <= 1'b0;
            stop_r    <= 1'b0;
            ack_r     <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            phase_r   <= phase_nxt_s;
            bit_cnt_r <= bit_cnt_nxt_s;
            shift_r   <= shift_nxt_s;
            done_r    <= (state_nxt_s == DONE);
            busy_r    <= (state_nxt_s != WAIT_EN);
            scl_r     <= scl_nxt_s;
            sda_en_r  <= sda_en_nxt_s;
            sda_out_r <= sda_out_nxt_s;
            if ((state_r == ACK_HOLD) && phase_end_s) begin
                data_r <= shift_r;
            end else begin
                data_r <= data_r;
            end
            if (accept_s) begin
                start_r <= start_frame;
                stop_r  <= stop_frame;
                ack_r   <= ack_last;
            end else begin
                start_r <= start_r;
                stop_r  <= stop_r;
                ack_r   <= ack_r;
            end
        end
    end

endmodule

// File: tb/tb_i2c_readframe.sv
`timescale 1ns/1ps
// Directed bench for i2c_readframe: a slave model drives sda while released,
// a bus monitor records event times, and scenarios are checked in sequence.
`define CHK(tag, obs, exp) \
    begin \
        n_assert++; \
        assert ((obs) === (exp)) else begin \
            n_fail++; \
            $error("FAIL %s observed=%0d expected=%0d", tag, (obs), (exp)); \
        end \
    end

module tb_i2c_readframe;
    localparam int DELAY  = 10;
    localparam int SAMPLE = 5;

    logic       clk_1MHz = 1'b0;
    logic       rst_n;
    logic       en_read;
    logic       start_frame;
    logic       stop_frame;
    logic       ack_last;
    wire        sda;
    logic       scl;
    logic       sda_en;
    logic [7:0] data;
    logic       done;
    logic       busy;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [7:0] slave_byte = 8'h00;
    logic       wiggle     = 1'b0;
    logic       slave_bit  = 1'b1;
    int         slave_idx  = 0;
    int         nidx;
    logic       mon_clr    = 1'b0;
    logic       prev_scl = 1'b1, prev_sda = 1'b1, prev_sda_en = 1'b1;
    int pulses = 0, hi_run = 0, hi_min = 999, hi_max = 0;
    int start_cyc = -1, stop_cyc = -1, ack_cyc = 0, ack_hi = 0, done_cnt = 0;
    logic ack_or = 1'b0, ack_hi_and = 1'b1;

    i2c_readframe #(.DELAY(DELAY), .SAMPLE(SAMPLE)) dut (
        .clk_1MHz    (clk_1MHz),
        .rst_n       (rst_n),
        .en_read     (en_read),
        .start_frame (start_frame),
        .stop_frame  (stop_frame),
        .ack_last    (ack_last),
        .sda         (sda),
        .scl         (scl),
        .sda_en      (sda_en),
        .data        (data),
        .done        (done),
        .busy        (busy)
    );

    assign sda = sda_en ? 1'bz : slave_bit;

    always #5 clk_1MHz = ~clk_1MHz;

    always @(posedge clk_1MHz) cyc <= cyc + 1;

    // Slave bit index: restarts while the master owns sda, advances as scl falls after a read pulse.
    always_comb begin
        if (sda_en !== 1'b0) nidx = 0;
        else if (prev_scl && !scl && !prev_sda_en) nidx = slave_idx + 1;
        else nidx = slave_idx;
    end

    // Slave drive and bus monitor, evaluated on the falling clock edge.
    always @(negedge clk_1MHz) begin
        slave_idx <= nidx;
        slave_bit <= ((nidx < 8) ? slave_byte[7 - nidx] : 1'b1)
                     ^ (wiggle && scl && !sda_en && (hi_run == SAMPLE + 1));
        prev_scl    <= scl;
        prev_sda    <= sda;
        prev_sda_en <= sda_en;
        if (mon_clr) begin
            pulses <= 0; hi_run <= 0; hi_min <= 999; hi_max <= 0;
            start_cyc <= -1; stop_cyc <= -1; ack_cyc <= 0; ack_hi <= 0;
            ack_or <= 1'b0; ack_hi_and <= 1'b1; done_cnt <= 0;
        end else begin
            if (!prev_scl && scl && !sda_en) pulses <= pulses + 1;
            if (scl && !sda_en) begin
                hi_run <= hi_run + 1;
            end else if (hi_run > 0) begin
                hi_run <= 0;
                if (hi_run < hi_min) hi_min <= hi_run;
                if (hi_run > hi_max) hi_max <= hi_run;
            end
            if (prev_scl && scl && prev_sda && (sda === 1'b0)) start_cyc <= cyc;
            if (prev_scl && scl && !prev_sda && (sda === 1'b1)) stop_cyc <= cyc;
            if ((pulses == 8) && sda_en && (ack_cyc < 3 * DELAY)) begin
                ack_cyc <= ack_cyc + 1;
                ack_or  <= ack_or | sda;
                if (scl) begin
                    ack_hi     <= ack_hi + 1;
                    ack_hi_and <= ack_hi_and & sda;
                end
            end
            if (done === 1'b1) done_cnt <= done_cnt + 1;
        end
    end

    task automatic launch(input logic s, input logic p, input logic a, input logic hold,
                          output int acc_o);
        @(negedge clk_1MHz);
        #1 mon_clr = 1'b1;
        @(negedge clk_1MHz);
        #1 mon_clr = 1'b0;
        start_frame = s; stop_frame = p; ack_last = a; en_read = 1'b1;
        @(posedge clk_1MHz);
        #1 acc_o = cyc;
        if (!hold) en_read = 1'b0;
    endtask

    task automatic wait_done(input int limit, output int dcyc);
        dcyc = -100000;
        for (int i = 0; (i < limit) && (dcyc < 0); i++) begin
            @(negedge clk_1MHz);
            if (done === 1'b1) dcyc = cyc;
        end
    endtask

    initial begin
        int acc, d, acc2, d2, bad, hit;
        rst_n = 1'b0; en_read = 1'b0; start_frame = 1'b0; stop_frame = 1'b0; ack_last = 1'b0;
        repeat (3) @(negedge clk_1MHz);
        `CHK("rst_scl", scl, 1'b1)
        `CHK("rst_sda_en", sda_en, 1'b1)
        `CHK("rst_sda", sda, 1'b1)
        `CHK("rst_data", data, 8'h00)
        `CHK("rst_done", done, 1'b0)
        `CHK("rst_busy", busy, 1'b0)
        #2 rst_n = 1'b1;

        // START + NACK + STOP, slave sends A5
        slave_byte = 8'hA5;
        launch(1'b1, 1'b1, 1'b1, 1'b0, acc);
        wait_done(400, d);
        `CHK("t2_done_lat", d - acc, 250)
        `CHK("t2_data", data, 8'hA5)
        `CHK("t2_start_lat", start_cyc - acc, 10)
        `CHK("t2_pulses", pulses, 8)
        `CHK("t2_hi_min", hi_min, 10)
        `CHK("t2_hi_max", hi_max, 10)
        `CHK("t2_ackhigh_len", ack_hi, 10)
        `CHK("t2_nack_sda", ack_hi_and, 1'b1)
        `CHK("t2_stop_lat", stop_cyc - acc, 240)
        @(negedge clk_1MHz);
        `CHK("t2_done_pulse", done, 1'b0)

        // plain frame with ACK, slave sends 3C
        slave_byte = 8'h3C;
        launch(1'b0, 1'b0, 1'b0, 1'b0, acc);
        wait_done(400, d);
        `CHK("t3_done_lat", d - acc, 190)
        `CHK("t3_data", data, 8'h3C)
        `CHK("t3_ack_window", ack_cyc, 30)
        `CHK("t3_ack_sda_low", ack_or, 1'b0)
        `CHK("t3_no_start", start_cyc, -1)
        repeat (20) @(negedge clk_1MHz);
        `CHK("t3_idle_scl", scl, 1'b0)
        `CHK("t3_idle_busy", busy, 1'b0)
        `CHK("t3_done_cnt", done_cnt, 1)

        // back-to-back frames with en_read held high: 81 then 7E
        slave_byte = 8'h81;
        launch(1'b0, 1'b0, 1'b0, 1'b1, acc);
        wait_done(400, d);
        `CHK("t4_done1_lat", d - acc, 190)
        `CHK("t4_data1", data, 8'h81)
        slave_byte = 8'h7E;
        acc2 = -100000;
        for (int i = 0; (i < 10) && (acc2 < 0); i++) begin
            @(negedge clk_1MHz);
            if (busy === 1'b1) acc2 = cyc;
        end
        `CHK("t4_rearm_gap", acc2 - d, 2)
        d2 = -100000; bad = 0;
        for (int i = 0; (i < 400) && (d2 < 0); i++) begin
            @(negedge clk_1MHz);
            if (done === 1'b1) d2 = cyc;
            else if (data !== 8'h81) bad++;
        end
        en_read = 1'b0;
        `CHK("t4_done2_lat", d2 - acc2, 190)
        `CHK("t4_data_hold", bad, 0)
        `CHK("t4_data2", data, 8'h7E)

        // sda wiggles one cycle after the sample point
        wiggle = 1'b1;
        slave_byte = 8'hC3;
        launch(1'b0, 1'b0, 1'b1, 1'b0, acc);
        wait_done(400, d);
        wiggle = 1'b0;
        `CHK("t5_done_lat", d - acc, 190)
        `CHK("t5_data", data, 8'hC3)

        // en_read pulse with different flags while busy is ignored
        slave_byte = 8'h5A;
        launch(1'b1, 1'b1, 1'b1, 1'b0, acc);
        repeat (60) @(negedge clk_1MHz);
        start_frame = 1'b0; stop_frame = 1'b0; ack_last = 1'b0; en_read = 1'b1;
        @(negedge clk_1MHz);
        en_read = 1'b0;
        wait_done(400, d);
        `CHK("t6_done_lat", d - acc, 250)
        `CHK("t6_data", data, 8'h5A)
        `CHK("t6_nack_kept", ack_hi_and, 1'b1)
        `CHK("t6_stop_lat", stop_cyc - acc, 240)
        repeat (10) @(negedge clk_1MHz);
        `CHK("t6_done_cnt", done_cnt, 1)

        // reset during the 4th ReadHigh
        slave_byte = 8'h96;
        launch(1'b0, 1'b0, 1'b0, 1'b0, acc);
        hit = 0;
        for (int i = 0; (i < 200) && (hit == 0); i++) begin
            @(negedge clk_1MHz);
            if (pulses >= 4) hit = 1;
        end
        `CHK("t1_reach_rh4", hit, 1)
        #2 rst_n = 1'b0;
        #1;
        `CHK("t1_async_scl", scl, 1'b1)
        `CHK("t1_async_sda_en", sda_en, 1'b1)
        `CHK("t1_async_sda", sda, 1'b1)
        `CHK("t1_async_data", data, 8'h00)
        `CHK("t1_async_done", done, 1'b0)
        `CHK("t1_async_busy", busy, 1'b0)
        @(negedge clk_1MHz);
        #2 rst_n = 1'b1;
        repeat (300) @(negedge clk_1MHz);
        `CHK("t6_no_done", done_cnt, 0)
        `CHK("t6_data_cleared", data, 8'h00)
        `CHK("t6_idle", busy, 1'b0)

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/i2c_readframe.md
Name: i2c_readframe

Overview:
I2C master-receiver frame engine: clocks one byte in from a slave on sda, then drives ACK or NACK, with optional START before and STOP after. It is the read-direction counterpart of the byte write-frame engine. A transaction sequencer above it chains frames: a write frame for address+R, then N read frames, the last one with NACK and STOP. Every bus phase lasts DELAY ticks of clk_1MHz.

Parameters:
DELAY, 10, length of one bus phase in clk_1MHz cycles (10 us at 1 MHz); legal range >= 2
SAMPLE, DELAY/2, cycle index within a ReadHigh phase at which sda is sampled; legal range 0..DELAY-1

Ports:
clk_1MHz  input  1  1 MHz clock
rst_n  input  1  asynchronous, active-low reset
en_read  input  1  request a frame; accepted only in WaitEn
start_frame  input  1  generate START before the byte; latched at accept
stop_frame  input  1  generate STOP after ACK/NACK; latched at accept
ack_last  input  1  1 = send NACK (last byte), 0 = send ACK; latched at accept
sda  inout  1  data line; sda = sda_en ? sda_out : 1'bz
scl  output  1  clock line, registered
sda_en  output  1  1 = master drives sda, 0 = released for slave
data  output  8  last received byte, MSB first
done  output  1  one-cycle pulse, frame complete, data valid
busy  output  1  high in every state except WaitEn

Behaviour:
- Reset (async): state = WaitEn, scl = 1, sda_en = 1, sda_out = 1, data = 8'h00, shift register = 0, bit counter = 0, phase counter = 0, latched flags = 0, done = 0.
- Phase counter runs 0..DELAY-1 in every timed state. On the cycle where it equals DELAY-1, the state advances and the counter returns to 0. Each timed state therefore lasts exactly DELAY cycles.
- Counter width is $clog2(DELAY). There is no wrap inside a phase.
- scl, sda_en and sda_out are registered. They take the entered state's values on the same edge the state register changes.
- Notation: value lists below give scl, sda_en, sda_out.
- WaitEn: scl, sda_en and sda_out hold their previous values, so scl stays low between chained frames. If en_read = 1, latch start_frame, stop_frame and ack_last, then go to PreStart if start_frame else ReadLow. No wait cycle.
- PreStart: 1, 1, 1.
- Start: 1, 1, 0. This is the START condition: sda falls while scl is high.
- AfterStart: 0, 1, 0. Then go to ReadLow.
- ReadLow: scl = 0, sda_en = 0.
- ReadHigh: scl = 1, sda_en = 0.
  - At counter == SAMPLE: shift register <= {shift[6:0], sda}; bit counter increments.
  - At phase end: go to AckLow if bit counter == 8, else ReadLow.
- AckLow: 0, 1, ack_last.
- AckHigh: 1, 1, ack_last. The slave samples ACK/NACK here.
- AckHold: 0, 1, ack_last.
  - At phase end: data <= shift register; bit counter <= 0.
  - Then go to PreStop if the latched stop_frame is set, else Done.
- PreStop: 0, 1, 0.
- StopHigh: 1, 1, 0.
- Stop: 1, 1, 1. This is the STOP condition: sda rises while scl is high. Then go to Done.
- Done: one cycle; done = 1; outputs hold. Always goes to WaitEn.
- Frame length: en_read sampled high at edge k, so done is high during the cycle after edge k + N*DELAY.
  - N = 19 with no START and no STOP.
  - N = 22 with exactly one of START or STOP.
  - N = 25 with both.
- Back-to-back: en_read held high means the next frame is accepted on the edge leaving WaitEn, i.e. 2 cycles after the previous done-entry edge.
- data changes only at AckHold end. It is stable through done and until the next frame completes.
- en_read, start_frame, stop_frame and ack_last are ignored outside WaitEn.
- The slave does no clock stretching; scl is not monitored. There is no timeout.
- Reset mid-frame: immediate return to reset values, which releases the bus. done is not pulsed and the partial byte is discarded.

Test Plan:
1. Assert rst_n = 0 mid-run -> scl = 1, sda_en = 1, sda = 1, data = 00, done = 0, busy = 0 with no clock edge required.
2. DELAY = 10, start = 1, stop = 1, ack_last = 1, slave model drives A5 -> expect all of:
   - START edge 10 cycles after accept; START = sda falls while scl = 1.
   - 8 scl high pulses of 10 cycles each.
   - sda_en = 1 and sda = 1 (NACK) during AckHigh.
   - STOP edge, sda rises while scl = 1.
   - done pulse 250 cycles after accept; data = A5.
3. start = 0, stop = 0, ack_last = 0, slave drives 3C -> sda = 0 throughout the AckLow, AckHigh and AckHold phases; done at 190 cycles; data = 3C; scl remains 0 in WaitEn afterwards.
4. en_read held high, slave drives 81 then 7E -> first done with data = 81; second frame accepted 2 cycles after the first done-entry edge; data = 81 stays until the second done, then becomes 7E.
5. Slave toggles sda exactly one cycle after SAMPLE in every ReadHigh phase while presenting C3 at SAMPLE -> data = C3, confirming the single sample point.
6. Reset pulsed during the 4th ReadHigh; en_read pulsed during busy in a separate run -> after reset, no done and data = 00; the mid-frame en_read pulse causes no restart and frame timing is unchanged.
